// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, keyboard command bytes, frame layout.
// The frame helper returns the host-driven bits after the start bit, LSB first.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE,
    DONE,
    ERR
  } ps2_state_t;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESEND  = 8'hFE;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_LEN = 11;

  // {stop, odd parity, data}; bit 0 goes out first
  function automatic logic [9:0] ps2_frame_bits(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-flop synchronizer, FILTER_LEN-sample glitch filter, falling-edge pulse.
// Level and edge appear 2 + FILTER_LEN cycles after the pad changes; idle level is high.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      fall <= 1'b0;
      // any sample matching the current level restarts the run of differing samples
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync[1];
        fall  <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 11-bit frame clocked by the device, ACK check.
// Build option PS2_TX_RETRY_EN: the first NACK/timeout of a request restarts it once from INHIBIT.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 2);
  localparam logic [3:0]    LAST_BIT = 4'(PS2_FRAME_LEN - 2);

  ps2_state_t    state, state_n;
  logic [7:0]    data_q, data_n;
  logic [3:0]    bit_cnt, bit_n;
  logic [IW-1:0] inh_cnt, inh_n;
  logic [WW-1:0] wdog, wdog_n;
  logic          d_oe, d_oe_n;
  logic          fail, expire;
  logic [9:0]    frame;
  logic          c_lvl, c_fall, d_lvl, d_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
    .clk(clk), .rst_n(clr), .raw(ps2c_in), .level(c_lvl), .fall(c_fall)
  );
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
    .clk(clk), .rst_n(clr), .raw(ps2d_in), .level(d_lvl), .fall(d_fall_unused)
  );

  assign frame  = ps2_frame_bits(data_q);
  assign expire = (wdog == WD_LAST);

`ifdef PS2_TX_RETRY_EN
  logic retried, retry_n;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) retried <= 1'b0;
    else      retried <= retry_n;
  end
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      data_q  <= '0;
      bit_cnt <= '0;
      inh_cnt <= '0;
      wdog    <= '0;
      d_oe    <= 1'b0;
    end else begin
      state   <= state_n;
      data_q  <= data_n;
      bit_cnt <= bit_n;
      inh_cnt <= inh_n;
      wdog    <= wdog_n;
      d_oe    <= d_oe_n;
    end
  end

  always_comb begin
    state_n = state;
    data_n  = data_q;
    bit_n   = bit_cnt;
    inh_n   = inh_cnt;
    wdog_n  = wdog;
    d_oe_n  = d_oe;
    fail    = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_n = retried;
`endif
    if (state == SHIFT || state == ACK || state == WAIT_IDLE)
      wdog_n = c_fall ? '0 : wdog + 1'b1;

    case (state)
      IDLE: begin
        if (tx_start) begin
          data_n  = tx_data;
          inh_n   = '0;
          state_n = INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_n = 1'b0;
`endif
        end
      end
      INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          d_oe_n  = 1'b1;
          state_n = REQ;
        end else begin
          inh_n = inh_cnt + 1'b1;
        end
      end
      REQ: begin
        bit_n   = '0;
        wdog_n  = '0;
        state_n = SHIFT;
      end
      // a device clock edge always beats a watchdog expiry in the same cycle
      SHIFT: begin
        if (c_fall) begin
          d_oe_n = ~frame[bit_cnt];
          bit_n  = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) state_n = ACK;
        end else begin
          fail = expire;
        end
      end
      ACK: begin
        if (c_fall) begin
          if (d_lvl) fail = 1'b1;
          else       state_n = WAIT_IDLE;
        end else begin
          fail = expire;
        end
      end
      WAIT_IDLE: begin
        if (c_lvl && d_lvl) state_n = DONE;
        else                fail    = expire;
      end
      default: begin
        state_n = IDLE;
`ifdef PS2_TX_RETRY_EN
        retry_n = 1'b0;
`endif
      end
    endcase

    if (fail) begin
      d_oe_n  = 1'b0;
      state_n = ERR;
`ifdef PS2_TX_RETRY_EN
      if (!retried) begin
        retry_n = 1'b1;
        inh_n   = '0;
        state_n = INHIBIT;
      end
`endif
    end
  end

  assign ps2c_oe = (state == INHIBIT);
  assign ps2d_oe = d_oe;
  assign busy    = (state == INHIBIT) || (state == REQ) || (state == SHIFT) ||
                   (state == ACK) || (state == WAIT_IDLE);
  assign tx_done = (state == DONE);
  assign tx_err  = (state == ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device with 40-cycle clock, vector table, random bytes, corner cases.
// Expectations follow PS2_TX_RETRY_EN when the bench is built with it.
module tb_ps2_host_tx;
  import ps2_pkg::*;

`ifdef PS2_TX_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, busy, tx_done, tx_err;

  ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(500), .FILTER_LEN(4)) dut (
    .clk(clk), .clr(clr), .tx_data(tx_data), .tx_start(tx_start),
    .ps2c_in(ps2c_in), .ps2d_in(ps2d_in), .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe),
    .busy(busy), .tx_done(tx_done), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // odd parity computed by counting ones, not by reduction
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // open-collector wires: device and host both pull low
  logic dev_c = 1'b1, dev_d = 1'b1;
  bit   dev_silent = 1'b0, dev_glitch = 1'b0;
  int   dev_bit = 0;
  int   nack_until = 0;
  logic [10:0] frames[$];

  assign ps2c_in = dev_c & ~ps2c_oe;
  assign ps2d_in = dev_d & ~ps2d_oe;

  initial begin : device
    logic [10:0] f;
    forever begin
      dev_bit = 0;
      while (ps2c_in) @(negedge clk);
      while (!(ps2c_in && !ps2d_in)) @(negedge clk);
      if (!dev_silent) begin
        repeat (20) @(negedge clk);
        f[0] = ps2d_in;
        for (int i = 1; i <= 10; i++) begin
          dev_c = 1'b0;
          repeat (20) @(negedge clk);
          dev_c   = 1'b1;
          f[i]    = ps2d_in;
          dev_bit = i;
          if (dev_glitch && i == 4) begin
            repeat (8) @(negedge clk);
            dev_c = 1'b0;
            repeat (2) @(negedge clk);
            dev_c = 1'b1;
            repeat (10) @(negedge clk);
          end else begin
            repeat (20) @(negedge clk);
          end
        end
        if (frames.size() >= nack_until) dev_d = 1'b0;
        repeat (5) @(negedge clk);
        dev_c = 1'b0;
        repeat (20) @(negedge clk);
        dev_c = 1'b1;
        repeat (5) @(negedge clk);
        dev_d = 1'b1;
        frames.push_back(f);
      end
    end
  end

  int   cyc = 0, done_n = 0, err_n = 0, inh_n = 0, inh_run = 0, inh_len = 0;
  int   req_cyc = 0, err_cyc = 0, bad_n = 0;
  logic req_d = 1'b0, prev_c_oe = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tx_done) done_n <= done_n + 1;
    if (tx_err) begin
      err_n   <= err_n + 1;
      err_cyc <= cyc;
    end
    inh_run <= ps2c_oe ? inh_run + 1 : 0;
    if (prev_c_oe && !ps2c_oe) begin
      inh_len <= inh_run;
      inh_n   <= inh_n + 1;
      req_cyc <= cyc;
      req_d   <= ps2d_oe;
    end
    if (((tx_done || tx_err) && (busy || ps2c_oe || ps2d_oe || !prev_busy || (tx_done && tx_err))) ||
        (ps2c_oe && !busy))
      bad_n <= bad_n + 1;
    prev_c_oe <= ps2c_oe;
    prev_busy <= busy;
  end

  initial begin : global_guard
    repeat (80000) @(posedge clk);
    $display("FAIL global_timeout: simulation still running after 80000 cycles");
    $fatal(1);
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_end(input int limit, output logic end_d);
    int n;
    n = 0;
    while (!(tx_done || tx_err) && n < limit) begin
      @(negedge clk);
      n++;
    end
    end_d = ps2d_oe;
    chk("end_seen", int'(tx_done || tx_err), 1);
    repeat (60) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  data;
    bit          nack;
    logic [10:0] frame;
    bit          done;
    bit          err;
  } vec_t;

  vec_t vecs[6];

  initial begin : main
    int d0, e0, i0, f0, n;
    logic end_d;
    logic [7:0] b;

    vecs[0] = '{PS2_CMD_SET_LED, 1'b0, 11'h7DA, 1'b1, 1'b0};
    vecs[1] = '{8'h00,           1'b0, 11'h600, 1'b1, 1'b0};
    vecs[2] = '{8'h01,           1'b0, 11'h402, 1'b1, 1'b0};
    vecs[3] = '{PS2_CMD_RESET,   1'b0, 11'h7FE, 1'b1, 1'b0};
    vecs[4] = '{PS2_CMD_RESEND,  1'b0, 11'h5FC, 1'b1, 1'b0};
    vecs[5] = '{PS2_CMD_RESET,   1'b1, 11'h7FE, RETRY, !RETRY};

    clr = 1'b0;
    tx_start = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ps2c_oe", int'(ps2c_oe), 0);
    chk("rst_ps2d_oe", int'(ps2d_oe), 0);
    chk("rst_busy",    int'(busy), 0);
    chk("rst_tx_done", int'(tx_done), 0);
    chk("rst_tx_err",  int'(tx_err), 0);
    clr = 1'b1;
    repeat (5) @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      d0 = done_n; e0 = err_n; i0 = inh_n; f0 = frames.size();
      nack_until = frames.size() + (vecs[k].nack ? 1 : 0);
      send(vecs[k].data);
      wait_end(3000, end_d);
      chk($sformatf("vec%0d_done", k), done_n - d0, int'(vecs[k].done));
      chk($sformatf("vec%0d_err", k), err_n - e0, int'(vecs[k].err));
      chk($sformatf("vec%0d_frames", k), frames.size() - f0, (RETRY && vecs[k].nack) ? 2 : 1);
      chk($sformatf("vec%0d_frame", k), int'(frames[$]), int'(vecs[k].frame));
      chk($sformatf("vec%0d_inhibits", k), inh_n - i0, (RETRY && vecs[k].nack) ? 2 : 1);
      chk($sformatf("vec%0d_inh_len", k), inh_len, 20);
      chk($sformatf("vec%0d_req_start", k), int'(req_d), 1);
      chk($sformatf("vec%0d_oe_idle", k), int'(ps2c_oe | ps2d_oe), 0);
    end

    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom_range(0, 255));
      d0 = done_n; e0 = err_n;
      nack_until = frames.size();
      send(b);
      wait_end(3000, end_d);
      chk($sformatf("rnd%0d_frame_%02h", k, b), int'(frames[$]), int'(model_frame(b)));
      chk($sformatf("rnd%0d_done", k), done_n - d0, 1);
      chk($sformatf("rnd%0d_err", k), err_n - e0, 0);
    end

    // second request during bit 4 must be dropped
    d0 = done_n; e0 = err_n; i0 = inh_n;
    nack_until = frames.size();
    send(8'hA3);
    n = 0;
    while (dev_bit != 4 && n < 2000) begin @(negedge clk); n++; end
    chk("ign_bit4_reached", dev_bit, 4);
    tx_data  = 8'h55;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_end(3000, end_d);
    chk("ign_frame", int'(frames[$]), int'(model_frame(8'hA3)));
    chk("ign_done", done_n - d0, 1);
    chk("ign_err", err_n - e0, 0);
    chk("ign_inhibits", inh_n - i0, 1);

    // asynchronous reset in the middle of a frame
    d0 = done_n; e0 = err_n;
    nack_until = frames.size();
    send(8'h3C);
    n = 0;
    while (!(dev_bit >= 3 && ps2d_oe) && n < 2000) begin @(negedge clk); n++; end
    chk("rst_mid_d_oe_before", int'(ps2d_oe), 1);
    chk("rst_mid_busy_before", int'(busy), 1);
    clr = 1'b0;
    #1;
    chk("rst_mid_ps2c_oe", int'(ps2c_oe), 0);
    chk("rst_mid_ps2d_oe", int'(ps2d_oe), 0);
    chk("rst_mid_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    clr = 1'b1;
    repeat (700) @(negedge clk);
    chk("rst_mid_no_done", done_n - d0, 0);
    chk("rst_mid_no_err", err_n - e0, 0);

    // short clock glitch must not shift an extra bit
    d0 = done_n; e0 = err_n;
    nack_until = frames.size();
    dev_glitch = 1'b1;
    send(8'h96);
    wait_end(3000, end_d);
    dev_glitch = 1'b0;
    chk("glitch_frame", int'(frames[$]), int'(model_frame(8'h96)));
    chk("glitch_done", done_n - d0, 1);
    chk("glitch_err", err_n - e0, 0);

    // device never clocks: watchdog
    d0 = done_n; e0 = err_n; i0 = inh_n;
    dev_silent = 1'b1;
    send(PS2_CMD_RESEND);
    wait_end(3000, end_d);
    dev_silent = 1'b0;
    chk("tmo_err", err_n - e0, 1);
    chk("tmo_no_done", done_n - d0, 0);
    chk("tmo_latency", err_cyc - req_cyc, 500);
    chk("tmo_d_released", int'(end_d), 0);
    chk("tmo_inhibits", inh_n - i0, RETRY ? 2 : 1);

    chk("pulse_and_oe_rules", bad_n, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
